mul_arbiter_seq: RTL and testbench

//  Sequencer and 2-way arbiter for the shared shift-add multiplier datapath (Load/Sh/Ad/M interface).

---
 rtl/mul_ctrl_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/mul_arbiter_seq.sv | 169 ++++++++++++++++
 tb/tb_mul_arbiter_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_ctrl_pkg
//  Shared definitions for the shift-add multiplier sequencer/arbiter.
//  - state_t : FSM state encoding (IDLE=0, ADD=1, SHIFT=2, DONE=3)
//  - N_DEFAULT : default operand width
// -----------------------------------------------------------------------------
package mul_ctrl_pkg;

  // Default operand width; the product is twice this wide.
  localparam int N_DEFAULT = 8;

  // Sequencer states. The encoding is fixed so that the state can be
  // observed on a debug bus with known values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Client index values, used for the Owner and Last registers.
  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//  Combinational 2-way round-robin arbiter.
//  Ports:
//    req  in  2  request vector, bit i = client i
//    last in  1  client that won the previous arbitration
//    gnt  out 2  one-hot (or zero) grant vector
//    sel  out 1  index of the winning client (meaningful only when |gnt)
//  On a tie the client that did NOT win last time is chosen; a single
//  requester always wins regardless of history.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       sel
);

  always_comb begin
    sel = 1'b0;
    if (req[0] && req[1]) begin
      sel = ~last;
    end else begin
      sel = req[1];
    end
  end

  // One grant line per client: asserted when anyone requests and the
  // selector points at that client.
  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt[gi] = (|req) && (sel == 1'(gi));
  end

endmodule

// File: rtl/mul_arbiter_seq.sv
// -----------------------------------------------------------------------------
// mul_arbiter_seq
//  Sequencer and 2-way arbiter for a shared shift-add multiplier datapath.
//  Two clients request multiplies; the winner's operands are muxed onto
//  OpA/OpB with Load, then N ADD/SHIFT pairs are issued, the 2N-bit product
//  is captured into Result and a one-cycle Done pulse goes to the owner.
//  Ports:
//    Clk          in   1   clock, rising edge
//    Reset_n      in   1   asynchronous active-low reset
//    Req0/Req1    in   1   client requests (held with stable operands until Gnt)
//    A0/A1,B0/B1  in   N   client operands (multiplicand / multiplier)
//    Gnt0/Gnt1    out  1   operands sampled this cycle
//    Done0/Done1  out  1   Result valid for that client (one cycle)
//    Result       out  2N  captured product, held until the next capture
//    Busy         out  1   sequencer not idle
//    Load,Sh,Ad   out  1   datapath controls (mutually exclusive)
//    OpA,OpB      out  N   operands to datapath (0 when not granting)
//    M            in   1   datapath multiplier-register LSB
//    Prod         in   2N  datapath product register
//  Latency: Gnt at cycle T gives Done at T+2N+2; the Done cycle may grant again.
// -----------------------------------------------------------------------------
module mul_arbiter_seq
  import mul_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Req0,
  input  logic           Req1,
  input  logic [N-1:0]   A0,
  input  logic [N-1:0]   A1,
  input  logic [N-1:0]   B0,
  input  logic [N-1:0]   B1,
  output logic           Gnt0,
  output logic           Gnt1,
  output logic           Done0,
  output logic           Done1,
  output logic [2*N-1:0] Result,
  output logic           Busy,
  output logic           Load,
  output logic           Sh,
  output logic           Ad,
  output logic [N-1:0]   OpA,
  output logic [N-1:0]   OpB,
  input  logic           M,
  input  logic [2*N-1:0] Prod
);

  // Bit counter width; cnt only ever holds 0..N-1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              last_reg, last_next;
  logic              owner_reg, owner_next;
  logic [2*N-1:0]    result_reg;
  logic              done0_reg, done1_reg;

  logic [1:0]        req_vec;
  logic [1:0]        arb_gnt;
  logic              arb_sel;

  // Requests are masked while reset is asserted so that no grant can leak
  // out combinationally during reset, even though IDLE is forced.
  assign req_vec = {Req1, Req0} & {2{Reset_n}};

  rr_arb2 u_arb (
    .req  (req_vec),
    .last (last_reg),
    .gnt  (arb_gnt),
    .sel  (arb_sel)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    Gnt0       = 1'b0;
    Gnt1       = 1'b0;
    Load       = 1'b0;
    Sh         = 1'b0;
    Ad         = 1'b0;
    OpA        = '0;
    OpB        = '0;

    case (state_reg)
      IDLE: begin
        // Arbitration only happens here, so requests raised while busy are
        // simply not seen until the sequencer returns to IDLE.
        if (|arb_gnt) begin
          Gnt0       = arb_gnt[0];
          Gnt1       = arb_gnt[1];
          Load       = 1'b1;
          OpA        = arb_sel ? A1 : A0;
          OpB        = arb_sel ? B1 : B0;
          owner_next = arb_sel;
          last_next  = arb_sel;
          cnt_next   = '0;
          state_next = ADD;
        end
      end

      ADD: begin
        // Add the multiplicand only when the current multiplier bit is set.
        Ad         = M;
        state_next = SHIFT;
      end

      SHIFT: begin
        Sh = 1'b1;
        // The terminal count is tested here so cnt never wraps past N-1.
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end else begin
          cnt_next   = cnt_reg + CW'(1);
          state_next = ADD;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= CLIENT1;   // makes client 0 win the first tie
      owner_reg  <= CLIENT0;
      result_reg <= '0;
      done0_reg  <= 1'b0;
      done1_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      owner_reg <= owner_next;

      // The product is complete while in DONE; capture it on the way out so
      // Result and Done appear together in the following IDLE cycle.
      if (state_reg == DONE) begin
        result_reg <= Prod;
      end
      done0_reg <= (state_reg == DONE) && (owner_reg == CLIENT0);
      done1_reg <= (state_reg == DONE) && (owner_reg == CLIENT1);
    end
  end

  assign Result = result_reg;
  assign Done0  = done0_reg;
  assign Done1  = done1_reg;
  assign Busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_arbiter_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter_seq
//  Bench for mul_arbiter_seq with N=8. Contains a shift-add datapath model
//  driven by the DUT controls, and a transaction-level reference model that
//  predicts grants, phase of each cycle, Done timing and Result from the
//  round-robin rule and A*B arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_arbiter_seq;

  localparam int N  = 8;
  localparam int W2 = 2 * N;
  localparam int LAT = 2 * N + 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Req0, Req1;
  logic [N-1:0]  A0, A1, B0, B1;
  logic          Gnt0, Gnt1, Done0, Done1, Busy, Load, Sh, Ad;
  logic [W2-1:0] Result;
  logic [N-1:0]  OpA, OpB;
  logic          M;
  logic [W2-1:0] Prod;

  always #5 Clk = ~Clk;

  mul_arbiter_seq #(.N(N)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Req0    (Req0),
    .Req1    (Req1),
    .A0      (A0),
    .A1      (A1),
    .B0      (B0),
    .B1      (B1),
    .Gnt0    (Gnt0),
    .Gnt1    (Gnt1),
    .Done0   (Done0),
    .Done1   (Done1),
    .Result  (Result),
    .Busy    (Busy),
    .Load    (Load),
    .Sh      (Sh),
    .Ad      (Ad),
    .OpA     (OpA),
    .OpB     (OpB),
    .M       (M),
    .Prod    (Prod)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Datapath model: {carry, accumulator, multiplier} register
  // ---------------------------------------------------------------------------
  logic [2*N:0]  acc  = '0;
  logic [N-1:0]  areg = '0;
  logic          dp_load = 1'b0, dp_sh = 1'b0, dp_ad = 1'b0;
  logic [N-1:0]  dp_opa = '0, dp_opb = '0;

  assign M    = acc[0];
  assign Prod = acc[W2-1:0];

  always @(posedge Clk) begin
    if (Reset_n) begin
      if (dp_load) begin
        acc  <= {{(N+1){1'b0}}, dp_opb};
        areg <= dp_opa;
      end else if (dp_ad) begin
        acc[2*N:N] <= acc[2*N:N] + {1'b0, areg};
      end else if (dp_sh) begin
        acc <= acc >> 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model (cycles since grant; 0 = idle)
  // ---------------------------------------------------------------------------
  int            m_k = 0;
  logic          m_last = 1'b1, m_owner = 1'b0, m_done_pend = 1'b0;
  logic [N-1:0]  m_a = '0, m_b = '0;
  logic [W2-1:0] m_result = '0;
  int            sh_cnt = 0, ad_cnt = 0;
  logic          e_g0, e_g1, e_ld, e_sh, e_ad, e_busy, e_d0, e_d1, granted, sel;
  logic [N-1:0]  e_oa, e_ob;

  always @(negedge Clk) begin
    dp_load = Load; dp_sh = Sh; dp_ad = Ad; dp_opa = OpA; dp_opb = OpB;
    if (!Reset_n) begin
      m_k = 0; m_last = 1'b1; m_owner = 1'b0; m_done_pend = 1'b0; m_result = '0;
      chk("rst_ctl", {Gnt0, Gnt1, Load, Sh, Ad, Done0, Done1, Busy}, 64'd0);
      chk("rst_op", {OpA, OpB}, 64'd0);
      chk("rst_result", Result, 64'd0);
    end else begin
      e_g0 = 0; e_g1 = 0; e_ld = 0; e_sh = 0; e_ad = 0; e_busy = 0;
      e_d0 = 0; e_d1 = 0; granted = 0; sel = 0; e_oa = '0; e_ob = '0;
      if (m_k == 0) begin
        if (m_done_pend) begin
          e_d0 = !m_owner; e_d1 = m_owner; m_done_pend = 1'b0;
        end
        if (Req0 || Req1) begin
          sel = (Req0 && Req1) ? !m_last : Req1;
          e_g0 = !sel; e_g1 = sel; e_ld = 1'b1;
          e_oa = sel ? A1 : A0;
          e_ob = sel ? B1 : B0;
          m_owner = sel; m_last = sel; m_a = e_oa; m_b = e_ob;
          granted = 1'b1; sh_cnt = 0; ad_cnt = 0;
        end
      end else begin
        e_busy = 1'b1;
        if (m_k <= 2 * N) begin
          if (m_k % 2 == 1) e_ad = M;
          else              e_sh = 1'b1;
        end
      end
      chk("gnt", {Gnt1, Gnt0}, {e_g1, e_g0});
      chk("load", Load, e_ld);
      chk("sh", Sh, e_sh);
      chk("ad", Ad, e_ad);
      chk("busy", Busy, e_busy);
      chk("done", {Done1, Done0}, {e_d1, e_d0});
      chk("opa", OpA, e_oa);
      chk("opb", OpB, e_ob);
      chk("result", Result, m_result);
      if (Sh) sh_cnt++;
      if (Ad) ad_cnt++;
      if (m_k == 2 * N + 1) begin
        chk("sh_count", sh_cnt, N);
        chk("ad_count", ad_cnt, $countones(m_b));
        m_result = W2'(m_a) * W2'(m_b);
        m_done_pend = 1'b1;
        m_k = 0;
        $display("txn client=%0d a=%0d b=%0d product=%0d", m_owner, m_a, m_b, m_result);
      end else if (granted) begin
        m_k = 1;
      end else if (m_k != 0) begin
        m_k++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic to_drive();
    @(posedge Clk); #1;
  endtask

  task automatic set_req(input int c, input logic r, input logic [N-1:0] a, input logic [N-1:0] b);
    if (c == 0) begin Req0 = r; A0 = a; B0 = b; end
    else        begin Req1 = r; A1 = a; B1 = b; end
  endtask

  // Wait (on negedges) for Gnt of client c, bounded.
  task automatic wait_gnt(input int c, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (((c == 0) ? Gnt0 : Gnt1) !== 1'b1 && n < 100);
    if (n >= 100) chk({tag, "_gnt_timeout"}, 64'd0, 64'd1);
  endtask

  // Wait (on negedges) for Done of client c; returns cycles waited.
  task automatic wait_done(input int c, input string tag, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (((c == 0) ? Done0 : Done1) !== 1'b1 && n < 100);
    if (n >= 100) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_one(input int c, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [W2-1:0] exp, input string tag);
    int n;
    to_drive();
    set_req(c, 1'b1, a, b);
    wait_gnt(c, tag);
    to_drive();
    set_req(c, 1'b0, a, b);
    wait_done(c, tag, n);
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_value"}, Result, exp);
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    bit g0, g1;
    Reset_n = 1'b0;
    // Both clients already requesting during reset.
    Req0 = 1'b1; A0 = 8'd3; B0 = 8'd5;
    Req1 = 1'b1; A1 = 8'd7; B1 = 8'd9;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Tie after reset: client 0 first, then client 1 on the Done0 cycle.
    wait_gnt(0, "tie");
    to_drive();
    Req0 = 1'b0;
    wait_done(0, "tie0", n);
    chk("tie0_value", Result, 64'd15);
    chk("tie_gnt1_on_done0", Gnt1, 1'b1);
    to_drive();
    Req1 = 1'b0;
    wait_done(1, "tie1", n);
    chk("tie1_latency", n, LAT);
    chk("tie1_value", Result, 64'd63);

    // Single requester and boundary operands.
    run_one(0, 8'd13, 8'd11, 16'd143, "c0_13x11");
    run_one(1, 8'd255, 8'd255, 16'd65025, "c1_max");
    run_one(0, 8'd0, 8'd200, 16'd0, "c0_zero");

    // Client 1 requests while client 0 is busy.
    to_drive();
    set_req(0, 1'b1, 8'd6, 8'd7);
    wait_gnt(0, "busy0");
    to_drive();
    Req0 = 1'b0;
    repeat (5) to_drive();
    set_req(1, 1'b1, 8'd2, 8'd10);
    wait_done(0, "busy0", n);
    chk("busy0_value", Result, 64'd42);
    chk("busy_gnt1_on_done0", Gnt1, 1'b1);
    to_drive();
    Req1 = 1'b0;
    wait_done(1, "busy1", n);
    chk("busy1_value", Result, 64'd20);

    // Reset during SHIFT with cnt=4 (cycle T+10 after the grant).
    to_drive();
    set_req(0, 1'b1, 8'd200, 8'd100);
    wait_gnt(0, "rst");
    to_drive();
    Req0 = 1'b0;
    repeat (10) @(negedge Clk);
    chk("rst_pre_sh", Sh, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_async_ctl", {Gnt0, Gnt1, Load, Sh, Ad, Done0, Done1, Busy}, 64'd0);
    chk("rst_async_result", Result, 64'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    run_one(1, 8'd9, 8'd9, 16'd81, "post_rst_c1");

    // Randomized traffic, including withdrawals and back-to-back requests.
    repeat (800) begin
      @(negedge Clk);
      g0 = Gnt0; g1 = Gnt1;
      to_drive();
      if (Req0 && !g0) begin
        if ($urandom_range(0, 39) == 0) Req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(0, 1'b1, rnd_op(), rnd_op());
      end else begin
        Req0 = 1'b0;
      end
      if (Req1 && !g1) begin
        if ($urandom_range(0, 39) == 0) Req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(1, 1'b1, rnd_op(), rnd_op());
      end else begin
        Req1 = 1'b0;
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    repeat (LAT + 6) @(posedge Clk);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
